accel_sample_fifo: RTL and testbench

- Sits directly downstream of the 16-tap signal path.
- On each `data_interrupt` pulse, captures one filtered {x,y,z} triple into an on-chip show-ahead FIFO.
- Tags each triple with a sequence number so the host can detect dropped samples.
- Exposes the FIFO to the bus-side reader with a pop handshake, a fill level, an overflow counter and a threshold interrupt.

---
 rtl/accel_sample_fifo.sv | 76 +++++++
 tb/tb_accel_sample_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/accel_sample_fifo.sv
// accel_sample_fifo: show-ahead FIFO of sequence-tagged {x,y,z} samples with level, overflow and threshold irq
module accel_sample_fifo #(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4,
   parameter int THRESHOLD = 8
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic [15:0]       x_data,
   input  logic [15:0]       y_data,
   input  logic [15:0]       z_data,
   input  logic              data_interrupt,
   input  logic              flush,
   input  logic              rd_en,
   output logic [15:0]       rd_x,
   output logic [15:0]       rd_y,
   output logic [15:0]       rd_z,
   output logic [7:0]        rd_seq,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic [15:0]       overflow_count,
   output logic              threshold_irq
);
   localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] TH_LVL   = (ADDR_W+1)'(THRESHOLD);
   localparam logic [ADDR_W:0] TH_PRE   = (ADDR_W+1)'(THRESHOLD - 1);
   logic [55:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [7:0]        seq;
   logic              wr, rd;
   logic [ADDR_W:0]   level_nxt;
   // a pop on a full FIFO frees the slot, so a coincident write is accepted
   always_comb begin
      rd        = rd_en && !empty;
      wr        = data_interrupt && (!full || rd);
      level_nxt = level + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
   end
   // sample storage; contents need no reset since level gates visibility
   always_ff @(posedge sys_clk)
      if (wr && !flush) mem[wr_ptr] <= {seq, x_data, y_data, z_data};
   // head entry straight from the registered read pointer
   always_comb {rd_seq, rd_x, rd_y, rd_z} = mem[rd_ptr];
   // pointers, level/flags, sequence tag, overflow count and threshold pulse
   always_ff @(posedge sys_clk or posedge reset)
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         empty          <= 1'b1;
         full           <= 1'b0;
         seq            <= '0;
         overflow_count <= '0;
         threshold_irq  <= 1'b0;
      end else begin
         seq <= seq + 8'(data_interrupt);
         if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            empty          <= 1'b1;
            full           <= 1'b0;
            overflow_count <= '0;
            threshold_irq  <= 1'b0;
         end else begin
            wr_ptr        <= wr_ptr + ADDR_W'(wr);
            rd_ptr        <= rd_ptr + ADDR_W'(rd);
            level         <= level_nxt;
            empty         <= level_nxt == '0;
            full          <= level_nxt == FULL_LVL;
            threshold_irq <= level == TH_PRE && level_nxt == TH_LVL;
            if (data_interrupt && !wr && overflow_count != 16'hFFFF)
               overflow_count <= overflow_count + 16'd1;
         end
      end
endmodule

// File: tb/tb_accel_sample_fifo.sv
// tb_accel_sample_fifo: directed and randomized checks of accel_sample_fifo against a queue model
module tb_accel_sample_fifo;
   localparam int DEPTH = 16;
   localparam int T     = 8;
   logic        sys_clk = 0, reset = 0;
   logic [15:0] x_data = 0, y_data = 0, z_data = 0;
   logic        data_interrupt = 0, flush = 0, rd_en = 0;
   logic [15:0] rd_x, rd_y, rd_z, overflow_count;
   logic [7:0]  rd_seq;
   logic        empty, full, threshold_irq;
   logic [4:0]  level;
   int n_vec = 0, n_err = 0;
   logic [55:0] q[$];
   int          ovf = 0;
   logic [7:0]  seq = 0;
   bit          exp_irq = 0;

   accel_sample_fifo #(.DEPTH(DEPTH), .ADDR_W(4), .THRESHOLD(T)) dut (
      .sys_clk(sys_clk), .reset(reset), .x_data(x_data), .y_data(y_data), .z_data(z_data),
      .data_interrupt(data_interrupt), .flush(flush), .rd_en(rd_en),
      .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z), .rd_seq(rd_seq), .empty(empty), .full(full),
      .level(level), .overflow_count(overflow_count), .threshold_irq(threshold_irq));

   always #5 sys_clk = ~sys_clk;

   // drive one cycle of inputs, advance the reference model, return 1 time unit after the edge
   task automatic cyc(input bit di, input bit rd, input bit fl,
                      input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      int n;
      data_interrupt = di; rd_en = rd; flush = fl; x_data = x; y_data = y; z_data = z;
      @(posedge sys_clk);
      n = q.size();
      exp_irq = 0;
      if (fl) begin
         q.delete();
         ovf = 0;
      end else begin
         if (rd && q.size() > 0) void'(q.pop_front());
         if (di) begin
            if (q.size() < DEPTH) q.push_back({seq, x, y, z});
            else if (ovf < 65535) ovf++;
         end
         exp_irq = (n == T - 1) && (q.size() == T);
      end
      if (di) seq++;
      #1;
      data_interrupt = 0; rd_en = 0; flush = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      @(posedge sys_clk);
      #1;
      reset = 0;
      q.delete(); ovf = 0; seq = 0; exp_irq = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
      n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
      n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      n_vec++; if (overflow_count !== 16'd0) begin n_err++; $display("FAIL reset_ovf got %0d want 0", overflow_count); end
      n_vec++; if (threshold_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", threshold_irq); end
   endtask

   task automatic test_order();
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 16'(3*i+1), 16'(3*i+2), 16'(3*i+3));
      n_vec++; if (level !== 5'd3) begin n_err++; $display("FAIL order_level got %0d want 3", level); end
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if ({rd_seq, rd_x, rd_y, rd_z} !== {8'(i), 16'(3*i+1), 16'(3*i+2), 16'(3*i+3)}) begin
            n_err++;
            $display("FAIL order_head%0d got seq=%0d x=%0d y=%0d z=%0d want seq=%0d x=%0d", i, rd_seq, rd_x, rd_y, rd_z, i, 3*i+1);
         end
         cyc(0, 1, 0, 0, 0, 0);
      end
      n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL order_empty got %b want 1", empty); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 20; i++) cyc(1, 0, 0, 16'(i), 16'(~i), 16'(i*7));
      n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b want 1", full); end
      n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level got %0d want 16", level); end
      n_vec++; if (overflow_count !== 16'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", overflow_count); end
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (rd_seq !== 8'(i) || rd_x !== 16'(i)) begin
            n_err++; $display("FAIL ovf_pop%0d got seq=%0d x=%0d want seq=%0d x=%0d", i, rd_seq, rd_x, i, i);
         end
         cyc(0, 1, 0, 0, 0, 0);
      end
      cyc(1, 0, 0, 16'h1234, 0, 0);
      n_vec++; if (rd_seq !== 8'd20 || rd_x !== 16'h1234) begin n_err++; $display("FAIL ovf_next got seq=%0d x=%h want seq=20 x=1234", rd_seq, rd_x); end
   endtask

   task automatic test_threshold();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cyc(1, 0, 0, 16'(i), 0, 0);
         if (threshold_irq) pulses++;
      end
      n_vec++; if (threshold_irq !== 1'b1) begin n_err++; $display("FAIL thr_after8 got %b want 1", threshold_irq); end
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0);
         if (threshold_irq) pulses++;
      end
      n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL thr_count got %0d want 1", pulses); end
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      n_vec++; if (threshold_irq !== 1'b1) begin n_err++; $display("FAIL thr_rearm got %b want 1", threshold_irq); end
      cyc(1, 0, 0, 0, 0, 0);
      n_vec++; if (threshold_irq !== 1'b0 || level !== 5'd9) begin n_err++; $display("FAIL thr_nine got irq=%b level=%0d want irq=0 level=9", threshold_irq, level); end
   endtask

   task automatic test_simul();
      do_reset();
      for (int i = 0; i < 16; i++) cyc(1, 0, 0, 16'(i), 0, 0);
      cyc(1, 1, 0, 16'hAAAA, 16'hBBBB, 16'hCCCC);
      n_vec++; if (level !== 5'd16 || full !== 1'b1) begin n_err++; $display("FAIL simul_full got level=%0d full=%b want 16 1", level, full); end
      n_vec++; if (overflow_count !== 16'd0) begin n_err++; $display("FAIL simul_ovf got %0d want 0", overflow_count); end
      n_vec++; if (rd_x !== 16'd1) begin n_err++; $display("FAIL simul_head got x=%0d want 1", rd_x); end
      for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 0, 0);
      n_vec++;
      if ({rd_seq, rd_x, rd_y, rd_z} !== {8'd16, 16'hAAAA, 16'hBBBB, 16'hCCCC}) begin
         n_err++; $display("FAIL simul_tail got seq=%0d x=%h want seq=16 x=aaaa", rd_seq, rd_x);
      end
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 16'h5555, 0, 0);
      n_vec++; if (level !== 5'd1 || rd_x !== 16'h5555) begin n_err++; $display("FAIL simul_empty got level=%0d x=%h want 1 5555", level, rd_x); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 18; i++) cyc(1, 0, 0, 16'(i), 0, 0);
      for (int i = 0; i < 11; i++) cyc(0, 1, 0, 0, 0, 0);
      n_vec++; if (level !== 5'd5 || overflow_count !== 16'd2) begin n_err++; $display("FAIL flush_pre got level=%0d ovf=%0d want 5 2", level, overflow_count); end
      cyc(1, 0, 1, 16'hDEAD, 0, 0);
      n_vec++; if (level !== 5'd0 || empty !== 1'b1) begin n_err++; $display("FAIL flush_level got level=%0d empty=%b want 0 1", level, empty); end
      n_vec++; if (overflow_count !== 16'd0 || threshold_irq !== 1'b0) begin n_err++; $display("FAIL flush_ovf got ovf=%0d irq=%b want 0 0", overflow_count, threshold_irq); end
      cyc(1, 0, 0, 16'hBEEF, 0, 0);
      n_vec++; if (rd_seq !== 8'd19 || rd_x !== 16'hBEEF) begin n_err++; $display("FAIL flush_seq got seq=%0d x=%h want 19 beef", rd_seq, rd_x); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 16'(i), 0, 0);
      n_vec++; if (level !== 5'd10) begin n_err++; $display("FAIL arst_pre got %0d want 10", level); end
      #2 reset = 1;
      #1;
      n_vec++;
      if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow_count !== 16'd0 || threshold_irq !== 1'b0) begin
         n_err++; $display("FAIL arst_now got level=%0d empty=%b full=%b ovf=%0d irq=%b want 0 1 0 0 0", level, empty, full, overflow_count, threshold_irq);
      end
      reset = 0;
      q.delete(); ovf = 0; seq = 0; exp_irq = 0;
      cyc(1, 0, 0, 16'h0077, 0, 0);
      n_vec++; if (rd_seq !== 8'd0 || level !== 5'd1) begin n_err++; $display("FAIL arst_seq got seq=%0d level=%0d want 0 1", rd_seq, level); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(99) < 55, $urandom_range(99) < 45, $urandom_range(999) < 8,
             16'($urandom), 16'($urandom), 16'($urandom));
         n_vec++; if (int'(level) !== q.size()) begin n_err++; $display("FAIL rnd_level c%0d got %0d want %0d", i, level, q.size()); end
         n_vec++; if (empty !== (q.size() == 0)) begin n_err++; $display("FAIL rnd_empty c%0d got %b want %b", i, empty, q.size() == 0); end
         n_vec++; if (full !== (q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full c%0d got %b want %b", i, full, q.size() == DEPTH); end
         n_vec++; if (int'(overflow_count) !== ovf) begin n_err++; $display("FAIL rnd_ovf c%0d got %0d want %0d", i, overflow_count, ovf); end
         n_vec++; if (threshold_irq !== exp_irq) begin n_err++; $display("FAIL rnd_irq c%0d got %b want %b", i, threshold_irq, exp_irq); end
         if (q.size() > 0) begin
            n_vec++;
            if ({rd_seq, rd_x, rd_y, rd_z} !== q[0]) begin n_err++; $display("FAIL rnd_head c%0d got %h want %h", i, {rd_seq, rd_x, rd_y, rd_z}, q[0]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_overflow();
      test_threshold();
      test_simul();
      test_flush();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
